// File: rtl/mod_pkg.sv
// Shared definitions for the modulo unit: default widths, controller state
// encoding and the datapath command decode type.
package mod_pkg;

  localparam int WIDTH_DEFAULT = 32;
  localparam int CNT_W_DEFAULT = 32;

  // Control-unit state encoding, shared by the CU and anything that models it.
  localparam logic [1:0] S0 = 2'd0;
  localparam logic [1:0] S1 = 2'd1;
  localparam logic [1:0] S2 = 2'd2;

  typedef enum logic [1:0] {
    CMD_NONE   = 2'd0,
    CMD_LOAD   = 2'd1,
    CMD_SUB    = 2'd2,
    CMD_COMMIT = 2'd3
  } dp_cmd_e;

endpackage

// File: rtl/mod_dp_if.sv
// Bus between the modulo datapath and its driver (ALU top plus control unit).
interface mod_dp_if
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
);

  logic             load;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             write_temp;
  logic             write_result;
  logic             lt;
  logic [WIDTH-1:0] result;
  logic             done;
  logic             div_zero;
  logic [CNT_W-1:0] iter_count;

  modport master (
    output load, a, b, write_temp, write_result,
    input  lt, result, done, div_zero, iter_count
  );

  modport slave (
    input  load, a, b, write_temp, write_result,
    output lt, result, done, div_zero, iter_count
  );

endinterface

// File: rtl/mod_cmp_sub.sv
// Combinational compare-and-subtract used by the modulo datapath.
module mod_cmp_sub
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] temp,
  input  logic [WIDTH-1:0] div,
  output logic             lt_raw,
  output logic [WIDTH-1:0] diff
);

  assign lt_raw = temp < div;
  assign diff   = temp - div;

endmodule

// File: rtl/mod_dp.sv
// Modulo datapath: holds dividend/divisor, reports lt to the control unit and
// executes its subtract/commit commands to compute a mod b.
module mod_dp
  import mod_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input logic     clk,
  input logic     reset,
  mod_dp_if.slave bus
);

  logic [WIDTH-1:0] temp_q, temp_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [CNT_W-1:0] iter_q, iter_d;

  logic             lt_raw;
  logic             lt;
  logic [WIDTH-1:0] diff;
  dp_cmd_e          cmd;

  mod_cmp_sub #(.WIDTH(WIDTH)) u_cmp_sub (
    .temp   (temp_q),
    .div    (div_q),
    .lt_raw (lt_raw),
    .diff   (diff)
  );

  // A zero divisor forces lt so the controller commits the dividend at once.
  assign lt = lt_raw | div_zero_q;

  always_comb begin
    cmd = CMD_NONE;
    if (bus.load) begin
      cmd = CMD_LOAD;
    end else if (bus.write_result) begin
      cmd = CMD_COMMIT;
    end else if (bus.write_temp && !lt) begin
      cmd = CMD_SUB;
    end
  end

  always_comb begin
    temp_d     = temp_q;
    div_d      = div_q;
    result_d   = result_q;
    done_d     = done_q;
    div_zero_d = div_zero_q;
    iter_d     = iter_q;
    case (cmd)
      CMD_LOAD: begin
        temp_d     = bus.a;
        div_d      = bus.b;
        result_d   = '0;
        done_d     = 1'b0;
        div_zero_d = (bus.b == '0);
        iter_d     = '0;
      end
      CMD_COMMIT: begin
        result_d = temp_q;
        done_d   = 1'b1;
      end
      CMD_SUB: begin
        temp_d = diff;
        iter_d = (iter_q == '1) ? iter_q : iter_q + CNT_W'(1);
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      temp_q     <= '0;
      div_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      iter_q     <= '0;
    end else begin
      temp_q     <= temp_d;
      div_q      <= div_d;
      result_q   <= result_d;
      done_q     <= done_d;
      div_zero_q <= div_zero_d;
      iter_q     <= iter_d;
    end
  end

  assign bus.lt         = lt;
  assign bus.result     = result_q;
  assign bus.done       = done_q;
  assign bus.div_zero   = div_zero_q;
  assign bus.iter_count = iter_q;

endmodule

// File: tb/tb_mod_dp.sv
// Bench for mod_dp: a registered control-unit model drives the datapath, and
// results are compared against plain a%b / a/b arithmetic.
module tb_mod_dp;
  import mod_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mod_dp_if #(.WIDTH(8), .CNT_W(8)) bus ();
  mod_dp #(.WIDTH(8), .CNT_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  mod_dp_if #(.WIDTH(8), .CNT_W(4)) sbus ();
  mod_dp #(.WIDTH(8), .CNT_W(4)) sdut (.clk(clk), .reset(reset), .bus(sbus));

  // Control unit with registered outputs, so its commands lag lt by a cycle.
  logic       cu_en = 1'b1;
  logic [1:0] cu_state;
  logic       cu_wt, cu_wr;
  logic       dir_wt = 1'b0;
  logic       dir_wr = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      cu_state <= S0; cu_wt <= 1'b0; cu_wr <= 1'b0;
    end else if (bus.load) begin
      cu_state <= S1; cu_wt <= 1'b1; cu_wr <= 1'b0;
    end else begin
      case (cu_state)
        S1: if (bus.lt) begin
              cu_state <= S2; cu_wt <= 1'b0; cu_wr <= 1'b1;
            end else begin
              cu_wt <= 1'b1; cu_wr <= 1'b0;
            end
        S2: begin cu_state <= S0; cu_wt <= 1'b0; cu_wr <= 1'b0; end
        default: begin cu_wt <= 1'b0; cu_wr <= 1'b0; end
      endcase
    end
  end

  assign bus.write_temp   = cu_en ? cu_wt : dir_wt;
  assign bus.write_result = cu_en ? cu_wr : dir_wr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv);
    @(negedge clk);
    bus.load = 1'b1; bus.a = av; bus.b = bv;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic waitDone(output int cyc);
    cyc = 0;
    while (!bus.done && cyc < 600) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic pulseDirect(input logic wt, input logic wr);
    dir_wt = wt; dir_wr = wr;
    @(negedge clk);
    dir_wt = 1'b0; dir_wr = 1'b0;
  endtask

  task automatic runAndCheck(input string tag, input logic [7:0] av, input logic [7:0] bv);
    int cyc;
    int q, r;
    q = (bv == 0) ? 0 : int'(av) / int'(bv);
    r = (bv == 0) ? int'(av) : int'(av) % int'(bv);
    applyStimulus(av, bv);
    checkOutput({tag, "_done_clr"}, 32'(bus.done), 32'd0);
    waitDone(cyc);
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(q + 2));
    checkOutput({tag, "_result"}, 32'(bus.result), 32'(r));
    checkOutput({tag, "_iter"}, 32'(bus.iter_count), 32'(q));
    checkOutput({tag, "_divzero"}, 32'(bus.div_zero), 32'(bv == 0));
    checkOutput({tag, "_lt_hold"}, 32'(bus.lt), 32'd1);
  endtask

  initial begin
    int cyc;
    logic found;
    logic [7:0] ra, rb;
    bus.load = 1'b0; bus.a = '0; bus.b = '0;
    sbus.load = 1'b0; sbus.a = '0; sbus.b = '0;
    sbus.write_temp = 1'b0; sbus.write_result = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_result", 32'(bus.result), 32'd0);
    checkOutput("rst_done", 32'(bus.done), 32'd0);
    checkOutput("rst_divzero", 32'(bus.div_zero), 32'd0);
    checkOutput("rst_iter", 32'(bus.iter_count), 32'd0);
    checkOutput("rst_lt", 32'(bus.lt), 32'd0);
    reset = 1'b0;

    runAndCheck("t1", 8'd17, 8'd5);

    applyStimulus(8'd3, 8'd7);
    checkOutput("t2_lt_now", 32'(bus.lt), 32'd1);
    waitDone(cyc);
    checkOutput("t2_latency", 32'(cyc), 32'd2);
    checkOutput("t2_result", 32'(bus.result), 32'd3);
    checkOutput("t2_iter", 32'(bus.iter_count), 32'd0);
    @(negedge clk);
    cu_en = 1'b0;
    pulseDirect(1'b1, 1'b0);
    checkOutput("t2_stray_result", 32'(bus.result), 32'd3);
    checkOutput("t2_stray_iter", 32'(bus.iter_count), 32'd0);
    pulseDirect(1'b0, 1'b1);
    checkOutput("t2_recommit", 32'(bus.result), 32'd3);
    cu_en = 1'b1;

    applyStimulus(8'd100, 8'd0);
    checkOutput("t3_divzero_now", 32'(bus.div_zero), 32'd1);
    checkOutput("t3_lt_now", 32'(bus.lt), 32'd1);
    waitDone(cyc);
    checkOutput("t3_latency", 32'(cyc), 32'd2);
    checkOutput("t3_result", 32'(bus.result), 32'd100);
    checkOutput("t3_iter", 32'(bus.iter_count), 32'd0);

    cu_en = 1'b0;
    applyStimulus(8'd9, 8'd4);
    pulseDirect(1'b1, 1'b1);
    checkOutput("t4_both_result", 32'(bus.result), 32'd9);
    checkOutput("t4_both_iter", 32'(bus.iter_count), 32'd0);
    checkOutput("t4_both_done", 32'(bus.done), 32'd1);
    pulseDirect(1'b1, 1'b0);
    checkOutput("t4_sub_iter", 32'(bus.iter_count), 32'd1);
    pulseDirect(1'b0, 1'b1);
    checkOutput("t4_sub_result", 32'(bus.result), 32'd5);
    cu_en = 1'b1;

    applyStimulus(8'd50, 8'd7);
    found = 1'b0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (bus.iter_count == 8'd3) found = 1'b1;
      else @(negedge clk);
    end
    checkOutput("t5_reach3", 32'(found), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t5_rst_result", 32'(bus.result), 32'd0);
    checkOutput("t5_rst_done", 32'(bus.done), 32'd0);
    checkOutput("t5_rst_iter", 32'(bus.iter_count), 32'd0);
    checkOutput("t5_rst_divzero", 32'(bus.div_zero), 32'd0);
    checkOutput("t5_rst_lt", 32'(bus.lt), 32'd0);
    reset = 1'b0;
    runAndCheck("t5_again", 8'd50, 8'd7);

    runAndCheck("t6_255_1", 8'd255, 8'd1);
    runAndCheck("t6_255_255", 8'd255, 8'd255);
    applyStimulus(8'd200, 8'd3);
    repeat (10) @(negedge clk);
    checkOutput("t6_midrun_done", 32'(bus.done), 32'd0);
    runAndCheck("t6_restart", 8'd10, 8'd3);

    // Counter saturation on a 4-bit iteration counter, driven directly.
    @(negedge clk);
    sbus.load = 1'b1; sbus.a = 8'd40; sbus.b = 8'd1;
    @(negedge clk);
    sbus.load = 1'b0; sbus.write_temp = 1'b1;
    repeat (20) @(negedge clk);
    sbus.write_temp = 1'b0;
    checkOutput("sat_iter", 32'(sbus.iter_count), 32'd15);
    sbus.write_result = 1'b1;
    @(negedge clk);
    sbus.write_result = 1'b0;
    checkOutput("sat_result", 32'(sbus.result), 32'd20);
    checkOutput("sat_done", 32'(sbus.done), 32'd1);

    for (int i = 0; i < 20; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      runAndCheck($sformatf("rnd%0d", i), ra, rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/mod_dp.md
Name: mod_dp

Overview:
- Datapath responder for the modulo control unit. It holds the dividend and divisor, and reports the comparison flag `lt` (temp < divisor) to the controller.
- It executes the controller's `write_temp` (subtract) and `write_result` (commit) commands, computing `a mod b` by repeated subtraction.
- It sits beside the modulo CU inside the ALU's mod unit. It exposes a load/done handshake to the ALU top and a divide-by-zero flag.

Parameters:
- WIDTH, 32, operand/result bit width (unsigned).
- CNT_W, 32, width of the iteration counter (saturating).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- load  in  1  latch new operands `a`, `b` and start a fresh operation.
- a  in  WIDTH  dividend (unsigned).
- b  in  WIDTH  divisor (unsigned).
- write_temp  in  1  from CU: replace temp with temp - divisor.
- write_result  in  1  from CU: commit temp to result.
- lt  out  1  to CU: temp < divisor, or divide-by-zero.
- result  out  WIDTH  registered modulo result.
- done  out  1  result valid; sticky until the next load or reset.
- div_zero  out  1  operation was loaded with b == 0.
- iter_count  out  CNT_W  number of accepted subtractions this operation.

Behaviour:
- Registers: temp_r, div_r, result, done, div_zero, iter_count.
- Reset (sync, active-high, highest priority): every register, and so every registered output, is 0. With temp_r = div_r = 0 and div_zero = 0, `lt` reads 0 after reset. Reset in mid-operation abandons the operation with no partial result.
- `lt` is combinational: (temp_r < div_r) | div_zero, unsigned compare, no latency.
- load (priority over write_*):
  - next edge: temp_r <= a, div_r <= b, result <= 0, done <= 0, iter_count <= 0, div_zero <= (b == 0).
  - write_temp and write_result in the same cycle are ignored.
- write_result = 1 (no load):
  - result <= temp_r and done <= 1 at the next edge; temp_r is unchanged.
  - If write_temp is also high, write_result wins and no subtraction occurs.
  - Repeated write_result re-commits the same value and is idempotent.
- write_temp = 1 (no load, no write_result):
  - If lt = 0: temp_r <= temp_r - div_r and iter_count <= iter_count + 1, saturating at all-ones.
  - If lt = 1: the command is ignored (underflow guard). This case is normal, because CU outputs are registered and lag `lt` by one cycle.
- Divide-by-zero: `lt` is forced to 1, so the CU goes straight to commit. The result is `a`, div_zero = 1, and iter_count = 0.
- Latency from load to done with the standard CU is N + 2 cycles after the load edge, where N = floor(a/b). One cycle covers the CU's registered lag; the commit takes the final edge.
- Once done = 1, the outputs are held until the next load. Further write_temp is ignored because lt = 1 at that point.
- The arithmetic is WIDTH-bit unsigned. The subtract never wraps, because it is only taken when temp_r >= div_r.

Decomposition:
- Shared package mod_pkg holds:
  - WIDTH_DEFAULT = 32 and CNT_W_DEFAULT = 32.
  - the CU state encoding (S0/S1/S2), so the CU and its bench share one definition.
- One natural sub-module, mod_cmp_sub. It is purely combinational: inputs temp and div; outputs lt_raw = temp < div and diff = temp - div. mod_dp instantiates it once and keeps all registers.

Test Plan:
1. Paired with the mod CU: load a=17, b=5 → done rises, result=2, iter_count=3, div_zero=0. Measure load-to-done latency = 5 cycles (N + 2 after the load edge).
2. a=3, b=7 (a < b): lt=1 immediately after load → result=3, iter_count=0, done=1. A stray write_temp after done leaves result and temp unchanged.
3. a=100, b=0 → div_zero=1, lt=1, result=100, iter_count=0, no subtraction ever.
4. Directly driven: write_temp and write_result asserted together with temp_r=9, div_r=4 → result=9, temp_r stays 9, iter_count unchanged.
5. Mid-operation: load a=50, b=7, assert reset after 3 subtractions → next cycle all outputs 0 and lt=0. A new load with a=50, b=7 then gives result=1, iter_count=7.
6. Boundaries with WIDTH=8: a=255, b=1 → result=0, iter_count=255. a=255, b=255 → result=0, iter_count=1. load during an active run with a=10, b=3 restarts cleanly → result=1.
